// File: rtl/ssled_scan.sv
// ssled_scan: multiplexed N-digit common-anode seven-segment scanner.
//   Ports: clk, rst_n (async active-low), n (nibble k -> digit k), dp (per-digit
//   decimal point), lzb (leading-zero blanking), blank (live force-dark),
//   seg {dp,g..a} active-low, an active-low one-hot-zero, frame_start pulse.
//   Optional macro SSLED_BRIGHTNESS_EN adds input bright[3:0] for PWM dimming.
// Latency: outputs registered; seg/an track the scan index in the same cycle
//   the prescaler enters a new slot. No backpressure.
module ssled_scan #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] n,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  lzb,
  input  logic                  blank,
`ifdef SSLED_BRIGHTNESS_EN
  input  logic [3:0]            bright,
`endif
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  logic [PW-1:0]         presc, presc_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [4*N_DIGITS-1:0] sh_n, sh_n_nxt;
  logic [N_DIGITS-1:0]   sh_dp, sh_dp_nxt;
  logic                  sh_lzb, sh_lzb_nxt;
  logic                  tick, wrap;

  assign tick = (presc == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(N_DIGITS - 1));

  // Everything visible is computed from next-state values and registered, so
  // the output pins line up exactly with the counter/shadow they depend on.
  always_comb begin
    presc_nxt  = tick ? '0 : presc + PW'(1);
    idx_nxt    = idx;
    if (tick) idx_nxt = wrap ? '0 : idx + IW'(1);
    sh_n_nxt   = wrap ? n   : sh_n;
    sh_dp_nxt  = wrap ? dp  : sh_dp;
    sh_lzb_nxt = wrap ? lzb : sh_lzb;
  end

`ifdef SSLED_BRIGHTNESS_EN
  logic [3:0] pwm_cnt, pwm_nxt;
  assign pwm_nxt = pwm_cnt + 4'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= 4'd0;
    else        pwm_cnt <= pwm_nxt;
  end
`endif

  logic [4*N_DIGITS-1:0] shifted;
  logic [3:0]            nib;
  logic                  hi_zero, blanked, guard, dark;
  logic [6:0]            dec;
  logic [7:0]            seg_nxt;
  logic [N_DIGITS-1:0]   an_nxt;

  always_comb begin
    // Shifting the selected nibble down to bit 0 also tells us whether this
    // digit and all more-significant ones are zero (leading-zero test).
    shifted = sh_n_nxt >> (4 * idx_nxt);
    nib     = shifted[3:0];
    hi_zero = (shifted == '0);
    blanked = sh_lzb_nxt && (idx_nxt != '0) && hi_zero;
    guard   = (presc_nxt < PW'(GUARD));
    case (nib)
      4'h0: dec = 7'b1000000;  4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;  4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;  4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;  4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;  4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;  4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;  4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;  default: dec = 7'b0001110;
    endcase
    // A blanked leading digit keeps its decimal point.
    seg_nxt = guard ? 8'hFF : {~sh_dp_nxt[idx_nxt], (blanked ? 7'h7F : dec)};
    dark    = guard || blank;
`ifdef SSLED_BRIGHTNESS_EN
    dark    = dark || !(pwm_nxt < bright);
`endif
    an_nxt  = dark ? '1 : ~(N_DIGITS'(1) << idx_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      sh_n        <= '0;
      sh_dp       <= '0;
      sh_lzb      <= 1'b0;
      seg         <= 8'hFF;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      presc       <= presc_nxt;
      idx         <= idx_nxt;
      sh_n        <= sh_n_nxt;
      sh_dp       <= sh_dp_nxt;
      sh_lzb      <= sh_lzb_nxt;
      seg         <= seg_nxt;
      an          <= an_nxt;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_ssled_scan.sv
module tb_ssled_scan;
  localparam int ND = 4, DIV = 8, GRD = 2;
  localparam int FRAME = ND * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] n = '0;
  logic [3:0]  dp = '0;
  logic        lzb = 1'b0, blank = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;
`ifdef SSLED_BRIGHTNESS_EN
  logic [3:0]  bright = 4'd15;
`endif

  ssled_scan #(.N_DIGITS(ND), .SCAN_DIV(DIV), .GUARD(GRD)) dut (
    .clk(clk), .rst_n(rst_n), .n(n), .dp(dp), .lzb(lzb), .blank(blank),
`ifdef SSLED_BRIGHTNESS_EN
    .bright(bright),
`endif
    .seg(seg), .an(an), .frame_start(frame_start));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: everything follows from the number of clock edges since
  // reset release and from what the inputs were at each frame boundary.
  int          cyc = 0;
  int          cur_d, cur_p;
  logic [15:0] m_n = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lzb = 1'b0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [3:0]  exp_an = 4'hF;
  logic        exp_fs = 1'b0;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[h];
  endfunction

  // Advance one clock edge and produce the expected outputs for the cycle after it.
  task automatic adv();
    logic bb;
    logic [15:0] hi;
    @(posedge clk);
    bb = blank;
    if (rst_n) begin
      cyc++;
      if (cyc % FRAME == 0) begin m_n = n; m_dp = dp; m_lzb = lzb; end
    end
    cur_p = cyc % DIV;
    cur_d = (cyc / DIV) % ND;
    exp_fs = (cyc > 0) && (cyc % FRAME == 0);
    hi = m_n >> (4 * cur_d);
    if (cur_p < GRD) begin
      exp_seg = 8'hFF; exp_an = 4'hF;
    end else begin
      exp_seg = {~m_dp[cur_d], ((m_lzb && cur_d != 0 && hi == 0) ? 7'h7F : hex7(hi[3:0]))};
      exp_an  = ~(4'b0001 << cur_d);
    end
    if (bb) exp_an = 4'hF;
`ifdef SSLED_BRIGHTNESS_EN
    if ((cyc % 16) >= int'(bright)) exp_an = 4'hF;
`endif
    #1;
  endtask

  task automatic model_reset();
    cyc = 0; m_n = '0; m_dp = '0; m_lzb = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      adv();
      n_cmp++; if (seg !== 8'hFF) begin n_bad++; $display("FAIL reset_seg got=%h want=ff", seg); end
      n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL reset_an got=%h want=f", an); end
      n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    end
    rst_n = 1'b1;
  endtask

  // First frame after reset must show zeros; afterwards the held value 1234.
  task automatic test_scan();
    n = 16'h1234; dp = '0; lzb = 0; blank = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      adv();
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL scan_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL scan_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      n_cmp++; if (frame_start !== exp_fs) begin n_bad++; $display("FAIL scan_fs cyc=%0d got=%b want=%b", cyc, frame_start, exp_fs); end
      if (cyc == 2) begin
        n_cmp++; if (seg !== 8'b11000000 || an !== 4'b1110) begin n_bad++; $display("FAIL first_frame_zero got=%b/%b want=11000000/1110", seg, an); end
      end
      if (cyc == FRAME + 2) begin
        n_cmp++; if (seg !== 8'b10011001 || an !== 4'b1110) begin n_bad++; $display("FAIL digit0_four got=%b/%b want=10011001/1110", seg, an); end
      end
      if (cyc == FRAME + 1) begin
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL guard_an got=%b want=1111", an); end
      end
    end
  endtask

  task automatic test_hex();
    logic [7:0] want [4] = '{8'b10100001, 8'b11000110, 8'b10000011, 8'b10001000};
    n = 16'hABCD;
    for (int i = 0; i < 2 * FRAME + DIV; i++) begin
      adv();
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL hex_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL hex_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      if (i >= FRAME + DIV && cur_p == GRD) begin
        n_cmp++; if (seg !== want[cur_d]) begin n_bad++; $display("FAIL hex_digit%0d got=%b want=%b", cur_d, seg, want[cur_d]); end
      end
    end
  endtask

  task automatic test_tearing();
    int changed = 0, wrapped = 0;
    n = 16'h1111;
    for (int i = 0; i < 4 * FRAME; i++) begin
      adv();
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL tear_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      n_cmp++; if (frame_start !== exp_fs) begin n_bad++; $display("FAIL tear_fs cyc=%0d got=%b want=%b", cyc, frame_start, exp_fs); end
      if (changed && exp_fs) wrapped = 1;
      if (changed && !wrapped && cur_d == 3 && cur_p >= GRD) begin
        n_cmp++; if (seg !== 8'b11111001) begin n_bad++; $display("FAIL tear_old_digit3 got=%b want=11111001", seg); end
      end
      if (wrapped && cur_p >= GRD) begin
        n_cmp++; if (seg !== 8'b10100100) begin n_bad++; $display("FAIL tear_new_digit%0d got=%b want=10100100", cur_d, seg); end
      end
      if (!changed && i > 2 * FRAME && cur_d == 2 && cur_p == 4) begin
        n = 16'h2222; changed = 1;
      end
    end
  endtask

  task automatic test_lzb();
    logic [7:0] w1 [4] = '{8'b11000000, 8'b10010010, 8'b01111111, 8'b11111111};
    logic [7:0] w2 [4] = '{8'b11000000, 8'b11111111, 8'b11111111, 8'b11111111};
    n = 16'h0050; dp = 4'b0100; lzb = 1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      adv();
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL lzb_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL lzb_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      if (i >= FRAME && cur_p == GRD + 1 && cyc >= FRAME) begin
        n_cmp++; if (seg !== w1[cur_d] && m_n == 16'h0050) begin n_bad++; $display("FAIL lzb_0050_digit%0d got=%b want=%b", cur_d, seg, w1[cur_d]); end
      end
    end
    n = 16'h0000; dp = 4'b0000;
    for (int i = 0; i < 2 * FRAME; i++) begin
      adv();
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL lzb0_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL lzb0_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      if (m_n == 16'h0000 && m_lzb && cur_p == GRD) begin
        n_cmp++; if (seg !== w2[cur_d]) begin n_bad++; $display("FAIL lzb_zero_digit%0d got=%b want=%b", cur_d, seg, w2[cur_d]); end
      end
    end
    lzb = 0;
  endtask

  task automatic test_blank_reset();
    int fs_seen = 0;
    blank = 1;
    for (int i = 0; i < FRAME + 4; i++) begin
      adv();
      n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL blank_an cyc=%0d got=%b want=1111", cyc, an); end
      n_cmp++; if (frame_start !== exp_fs) begin n_bad++; $display("FAIL blank_fs cyc=%0d got=%b want=%b", cyc, frame_start, exp_fs); end
      fs_seen += int'(frame_start);
    end
    n_cmp++; if (fs_seen != 1) begin n_bad++; $display("FAIL blank_fs_count got=%0d want=1", fs_seen); end
    blank = 0;
    n = 16'h8888; dp = 4'hF;
    while (!(cur_p == 5 && cyc > FRAME)) adv();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (seg !== 8'hFF) begin n_bad++; $display("FAIL async_rst_seg got=%h want=ff", seg); end
    n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL async_rst_an got=%h want=f", an); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL async_rst_fs got=%b want=0", frame_start); end
    model_reset();
    adv(); adv();
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + DIV; i++) begin
      adv();
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL post_rst_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL post_rst_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20 * FRAME; i++) begin
      adv();
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL rand_seg cyc=%0d got=%b want=%b", cyc, seg, exp_seg); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL rand_an cyc=%0d got=%b want=%b", cyc, an, exp_an); end
      n_cmp++; if (frame_start !== exp_fs) begin n_bad++; $display("FAIL rand_fs cyc=%0d got=%b want=%b", cyc, frame_start, exp_fs); end
      if ($urandom_range(0, 15) == 0) begin
        n = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp = 4'($urandom);
        lzb = 1'($urandom);
      end
      if ($urandom_range(0, 9) == 0) blank = ~blank;
    end
    blank = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_tearing();
    test_lzb();
    test_blank_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
